// File: rtl/bus_mux_arbiter.sv
// bus_mux_arbiter
//   N-channel, WIDTH-bit bus selector with a registered output word and a
//   valid/ready handshake. It replaces the old combinational 16:1 bus mux
//   and adds two ways of choosing the source channel:
//     mode 0 : direct select, where the control unit drives sel.
//     mode 1 : round-robin arbitration among requesting channels.
//   A new word is captured whenever the output slot is free, meaning it is
//   empty or being accepted this cycle, so there is no bubble under
//   continuous out_ready.
//
// Ports
//   clock     : system clock, rising edge.
//   resetn    : asynchronous active-low reset.
//   mode      : 0 = direct select, 1 = round-robin.
//   sel       : channel index for mode 0 (values >= N never capture).
//   req       : per-channel request; a channel is eligible only while set.
//   in_flat   : packed channel data; channel k at [k*WIDTH +: WIDTH].
//   out_ready : downstream accepts the held word.
//   out_valid : out_data/out_chan hold a captured word.
//   out_data  : captured channel data.
//   out_chan  : index of the captured channel.
//   grant     : one-cycle one-hot pulse naming the channel captured at the
//               last edge.
module bus_mux_arbiter #(
  parameter int WIDTH = 16,
  parameter int N     = 16,
  parameter int SEL_W = 4
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               mode,
  input  logic [SEL_W-1:0]   sel,
  input  logic [N-1:0]       req,
  input  logic [N*WIDTH-1:0] in_flat,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_chan,
  output logic [N-1:0]       grant
);

  // Request and grant vectors are widened to the full sel range so that
  // any sel value indexes in range; the pad bits are always zero.
  localparam int NPAD = 1 << SEL_W;

  logic [SEL_W-1:0] ptr_p0;
  logic [NPAD-1:0]  req_ext;
  logic [NPAD-1:0]  onehot_ext;
  logic             slot_free;
  logic             dir_hit;
  logic             rr_hit;
  logic [SEL_W-1:0] rr_idx;
  logic             load;
  logic [SEL_W-1:0] load_idx;
  logic [WIDTH-1:0] load_data;

  // (base + off) mod N, for base < N and 0 <= off < N. The wrap is mod N,
  // not mod 2^SEL_W, so non-power-of-two channel counts rotate correctly.
  function automatic logic [SEL_W-1:0] wrap_add(input logic [SEL_W-1:0] base,
                                                input int off);
    int s;
    s = int'(base) + off;
    if (s >= N) s = s - N;
    return s[SEL_W-1:0];
  endfunction

  always_comb begin
    req_ext        = '0;
    req_ext[N-1:0] = req;
  end

  // Round-robin search from ptr upward. The loop runs from the farthest
  // offset down to zero so that the nearest requesting channel is the last
  // (and therefore winning) assignment.
  always_comb begin
    rr_hit = 1'b0;
    rr_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_ext[wrap_add(ptr_p0, i)]) begin
        rr_hit = 1'b1;
        rr_idx = wrap_add(ptr_p0, i);
      end
    end
  end

  assign slot_free = !out_valid || out_ready;
  assign dir_hit   = (int'(sel) < N) && req_ext[sel];

  always_comb begin
    load       = mode ? rr_hit : dir_hit;
    load_idx   = mode ? rr_idx : sel;
    // load_idx is only consumed when load is set, and then it is below N.
    load_data  = in_flat[int'(load_idx)*WIDTH +: WIDTH];
    onehot_ext = '0;
    onehot_ext[load_idx] = 1'b1;
  end

  // ---- stage p0 -> output register ----
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      grant     <= '0;
      ptr_p0    <= '0;
    end else begin
      grant <= '0;
      if (slot_free) begin
        out_valid <= load;
        if (load) begin
          out_data <= load_data;
          out_chan <= load_idx;
          grant    <= onehot_ext[N-1:0];
        end
        if (mode && rr_hit) begin
          ptr_p0 <= wrap_add(rr_idx, 1);
        end
      end
    end
  end

endmodule
